// File: rtl/ms_seven_seg_fsm.sv
// Purpose: 8-digit common-anode seven-segment driver with a 1 ms timebase and a serial binary-to-BCD converter.
// Latency: anode/cathode are registered (1 cycle after index/display data); count reaches the display within 82 cycles.
// Backpressure: none. count is snapshotted once per 41-cycle conversion, while mode and decs are used live.
//
// Ports:
//   clock    - system clock, rising edge
//   reset    - synchronous, active-high
//   mode     - 0 decimal, 1 hex, 2/3 blank
//   count    - 39-bit unsigned value to display
//   decs     - decimal-point mask, bit i = digit i (digit 0 rightmost)
//   cathode  - active-low segments {dp,g,f,e,d,c,b,a}
//   anode    - active-low digit enables, one low at a time
//   ms_clock - 1 ms square wave, 50% duty
module ms_seven_seg_fsm #(
    parameter int DIV = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  mode,
    input  logic [38:0] count,
    input  logic [7:0]  decs,
    output logic [7:0]  cathode,
    output logic [7:0]  anode,
    output logic        ms_clock
);

    localparam int DW = $clog2(DIV);
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] HALF = DW'(DIV / 2);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;
    logic          tick;
    logic [2:0]    index;

    state_t        state;
    logic [38:0]   snap;
    logic [38:0]   bin_sr;
    logic [31:0]   bcd;
    logic [31:0]   bcd_adj;
    logic [5:0]    bit_cnt;
    logic [31:0]   dec_reg;
    logic [31:0]   hex_reg;

    logic [3:0]    cur_nib;
    logic [6:0]    seg_pat;

    always_comb begin
        tick    = (div_cnt == LAST);
        div_nxt = tick ? '0 : div_cnt + DW'(1);
    end

    // Double-dabble correction: any BCD nibble >= 5 becomes >= 10 after the
    // shift, so pre-add 3 to push the overflow into the next digit.
    // Only eight digits are kept; carries out of digit 7 are simply lost,
    // which yields count mod 10^8 exactly.
    always_comb begin
        bcd_adj = bcd;
        for (int n = 0; n < 8; n++) begin
            if (bcd[4*n +: 4] >= 4'd5)
                bcd_adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
        end
    end

    always_comb begin
        cur_nib = mode[0] ? hex_reg[{index, 2'b00} +: 4]
                          : dec_reg[{index, 2'b00} +: 4];
        case (cur_nib)
            4'h0:    seg_pat = 7'h40;
            4'h1:    seg_pat = 7'h79;
            4'h2:    seg_pat = 7'h24;
            4'h3:    seg_pat = 7'h30;
            4'h4:    seg_pat = 7'h19;
            4'h5:    seg_pat = 7'h12;
            4'h6:    seg_pat = 7'h02;
            4'h7:    seg_pat = 7'h78;
            4'h8:    seg_pat = 7'h00;
            4'h9:    seg_pat = 7'h10;
            4'hA:    seg_pat = 7'h08;
            4'hB:    seg_pat = 7'h03;
            4'hC:    seg_pat = 7'h46;
            4'hD:    seg_pat = 7'h21;
            4'hE:    seg_pat = 7'h06;
            default: seg_pat = 7'h0E;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt  <= '0;
            ms_clock <= 1'b0;
            index    <= 3'd0;
            state    <= IDLE;
            snap     <= '0;
            bin_sr   <= '0;
            bcd      <= '0;
            bit_cnt  <= '0;
            dec_reg  <= '0;
            hex_reg  <= '0;
            anode    <= 8'hFF;
            cathode  <= 8'hFF;
        end else begin
            div_cnt <= div_nxt;
            // Looking at the next count makes the rising edge land on the wrap.
            ms_clock <= (div_nxt < HALF);
            if (tick)
                index <= index + 3'd1;

            case (state)
                IDLE: begin
                    snap    <= count;
                    bin_sr  <= count;
                    bcd     <= '0;
                    bit_cnt <= '0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    bcd     <= {bcd_adj[30:0], bin_sr[38]};
                    bin_sr  <= {bin_sr[37:0], 1'b0};
                    bit_cnt <= bit_cnt + 6'd1;
                    if (bit_cnt == 6'd38)
                        state <= DONE;
                end
                DONE: begin
                    dec_reg <= bcd;
                    hex_reg <= snap[31:0];
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Output stage: index and display data as they stood before this edge.
            anode   <= ~(8'd1 << index);
            cathode <= mode[1] ? 8'hFF : {~decs[index], seg_pat};
        end
    end

endmodule

// File: tb/tb_ms_seven_seg_fsm.sv
module tb_ms_seven_seg_fsm;

    localparam int DIV = 10;
    localparam int CONV = 41;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic [38:0] count;
    logic [7:0]  decs;
    logic [7:0]  cathode;
    logic [7:0]  anode;
    logic        ms_clock;

    int checks = 0;
    int errors = 0;

    ms_seven_seg_fsm #(.DIV(DIV)) dut (
        .clock   (clock),
        .reset   (reset),
        .mode    (mode),
        .count   (count),
        .decs    (decs),
        .cathode (cathode),
        .anode   (anode),
        .ms_clock(ms_clock)
    );

    always #5 clock = ~clock;

    // Reference segment table (active low, {g,f,e,d,c,b,a}).
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [3:0] dec_digit(input longint unsigned v, input int i);
        longint unsigned t = v;
        for (int n = 0; n < i; n++) t = t / 10;
        return 4'(t % 10);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: k counts clock edges since reset released. The digit
    // index is k/DIV mod 8, conversions snapshot on every 41st edge and publish
    // count mod 10^8 (and the low 32 bits for hex) 40 edges later.
    longint unsigned k;
    logic [38:0]     m_snap;
    longint unsigned m_dec;
    logic [31:0]     m_hex;
    logic [7:0]      exp_anode, exp_cath;
    logic            exp_ms;
    bit              started = 0;

    always @(posedge clock) begin
        int idx;
        logic [3:0] d;
        if (reset) begin
            k = 0; m_snap = '0; m_dec = 0; m_hex = '0;
            exp_anode = 8'hFF; exp_cath = 8'hFF; exp_ms = 1'b0;
        end else begin
            idx = int'((k / DIV) % 8);
            exp_anode = ~(8'd1 << idx);
            d = (mode == 2'd1) ? m_hex[4*idx +: 4] : dec_digit(m_dec, idx);
            exp_cath = (mode >= 2'd2) ? 8'hFF : {~decs[idx], seg7(d)};
            if (k % CONV == 0) m_snap = count;
            if (k % CONV == CONV - 1) begin
                m_dec = longint'(m_snap) % 100000000;
                m_hex = m_snap[31:0];
            end
            k = k + 1;
            exp_ms = ((k % DIV) < DIV / 2);
        end
        started = 1;
    end

    always @(negedge clock) begin
        if (started) begin
            chk("anode", anode, exp_anode);
            chk("cathode", cathode, exp_cath);
            chk("ms_clock", {7'd0, ms_clock}, {7'd0, exp_ms});
        end
    end

    task automatic check_digit(input string name, input int i, input logic [7:0] exp);
        logic [7:0] tgt;
        bit ok;
        tgt = ~(8'd1 << i);
        ok = 0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clock);
            if (anode == tgt) ok = 1;
        end
        if (ok) chk(name, cathode, exp);
        else begin
            checks++; errors++;
            $display("FAIL %s: digit %0d never enabled, anode %02h expected %02h", name, i, anode, tgt);
        end
    endtask

    task automatic wait_phase(input int ph);
        bit ok;
        ok = 0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clock);
            if (k % CONV == ph) ok = 1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL phase_wait: phase %0d not reached, got %0d expected %0d", ph, k % CONV, ph);
        end
    endtask

    localparam longint unsigned VAL_A = 87654321;
    localparam longint unsigned VAL_B = 12345678;

    initial begin
        int hi, n_fe, n_7f, idx;
        logic [63:0] r;

        reset = 1'b1; mode = 2'd0; count = '0; decs = 8'h00;

        // Reset held: outputs parked.
        repeat (5) begin
            @(negedge clock);
            chk("rst_anode", anode, 8'hFF);
            chk("rst_cathode", cathode, 8'hFF);
            chk("rst_ms", {7'd0, ms_clock}, 8'h00);
        end
        reset = 1'b0;
        @(negedge clock);
        chk("first_anode", anode, 8'hFE);
        chk("first_cathode", cathode, 8'hC0);

        // Divider and scan duty over whole periods.
        repeat (20) @(negedge clock);
        hi = 0; n_fe = 0; n_7f = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clock);
            if (ms_clock) hi++;
            if (anode == 8'hFE) n_fe++;
            if (anode == 8'h7F) n_7f++;
        end
        chk("ms_high_cycles", 8'(hi), 8'd40);
        chk("dwell_digit0", 8'(n_fe), 8'd10);
        chk("dwell_digit7", 8'(n_7f), 8'd10);

        // Decimal with decimal points on digits 3 and 5.
        count = 39'(VAL_B); decs = 8'b0010_1000;
        repeat (90) @(negedge clock);
        check_digit("dec_d0", 0, 8'h80);
        check_digit("dec_d3", 3, 8'h12);
        check_digit("dec_d5", 5, 8'h30);
        check_digit("dec_d7", 7, 8'hF9);

        // Only the low eight decimal digits survive: 549755813887 -> 55813887.
        count = 39'h7F_FFFF_FFFF; decs = 8'h00;
        repeat (90) @(negedge clock);
        check_digit("trunc_d0", 0, 8'hF8);
        check_digit("trunc_d4", 4, 8'hF9);
        check_digit("trunc_d7", 7, 8'h92);

        // Hex.
        mode = 2'd1; count = 39'h0_DEAD_BEEF;
        repeat (90) @(negedge clock);
        check_digit("hex_d0", 0, 8'h8E);
        check_digit("hex_d3", 3, 8'h83);
        check_digit("hex_d7", 7, 8'hA1);

        // Blank: every digit dark while scanning continues.
        mode = 2'd2; decs = 8'hFF;
        for (int c = 0; c < 80; c++) begin
            @(negedge clock);
            chk("blank", cathode, 8'hFF);
        end

        // Count change during SHIFT: old value must complete first.
        mode = 2'd0; decs = 8'h00; count = 39'(VAL_A);
        repeat (50) @(negedge clock);
        wait_phase(5);
        count = 39'(VAL_B);
        wait_phase(0);
        @(negedge clock);
        idx = int'(((k - 1) / DIV) % 8);
        chk("midconv_old", cathode, {1'b1, seg7(dec_digit(VAL_A, idx))});
        wait_phase(0);
        @(negedge clock);
        idx = int'(((k - 1) / DIV) % 8);
        chk("midconv_new", cathode, {1'b1, seg7(dec_digit(VAL_B, idx))});

        // Randomised traffic, including a mid-run reset.
        for (int it = 0; it < 60; it++) begin
            r = {$urandom, $urandom};
            count = r[38:0];
            mode = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            decs = 8'($urandom);
            repeat ($urandom_range(5, 60)) @(negedge clock);
            if (it == 30) begin
                reset = 1'b1;
                repeat (2) @(negedge clock);
                reset = 1'b0;
            end
        end
        repeat (100) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
